ffi_gamma_ctrl: RTL and testbench
=================================

Name: ffi_gamma_ctrl

Overview:
- Sequences feedforward inhibition (FFI) across one gamma cycle of GAMMA_LEN time steps for a column of NUM_SPIKES active-low spike lines.
- Each line may fire at most once per gamma cycle.
- Admits spikes only while the cumulative admitted count stays within FFI_MAX; all later spikes in the cycle are inhibited.
- Sits between the neuron-body outputs and the downstream WTA/STDP logic; owns gamma-cycle timing for the column.

Parameters:
- NUM_SPIKES, 16, number of spike lines.
- FFI_MAX, 4, max spikes admitted per gamma cycle (1..NUM_SPIKES).
- GAMMA_LEN, 8, time steps per gamma cycle (>=2).
- CNT_W, $clog2(NUM_SPIKES+1), admitted-count width. Must hold NUM_SPIKES without wrap.
- STEP_W, $clog2(GAMMA_LEN), step-counter width.

Ports:
- clk, input, 1, single clock.
- rst_l, input, 1, asynchronous active-low reset.
- start, input, 1, begin a gamma cycle. Honoured only in IDLE.
- step_en, input, 1, advance one time step this cycle. When low in RUN, all state holds.
- should_spike_in_l, input, NUM_SPIKES, active-low spike requests for the current step.
- should_spike_out, output, NUM_SPIKES, admitted spikes for the step. Registered, one-hot-per-line pulse.
- fired_mask, output, NUM_SPIKES, sticky set of lines admitted this gamma cycle.
- spike_count, output, CNT_W, number of admitted spikes this gamma cycle.
- inhibited, output, 1, high once spike_count == FFI_MAX in the current cycle.
- busy, output, 1, high in RUN.
- done, output, 1, one-cycle pulse in DONE.
- step, output, STEP_W, current time-step index.

Behaviour:
- Reset (rst_l low, async): state = IDLE. All outputs are 0: should_spike_out, fired_mask, spike_count, inhibited, busy, done, step.
- Reset asserted mid-cycle aborts the cycle immediately. No done pulse is produced.

State machine:
- IDLE:
  - On start=1, go to RUN next edge.
  - On that edge: clear fired_mask, spike_count, inhibited and step. should_spike_out = 0.
- RUN, on each edge with step_en=1:
  - cand = ~should_spike_in_l & ~fired_mask. Lines already fired are ignored.
  - budget = FFI_MAX - spike_count.
  - Admit the lowest-indexed set bits of cand, up to budget bits. Higher-indexed excess candidates are dropped for this cycle; they are not queued.
  - should_spike_out <= admitted vector.
  - fired_mask |= admitted.
  - spike_count += popcount(admitted).
  - inhibited <= (new spike_count == FFI_MAX).
  - If step == GAMMA_LEN-1, go to DONE. Otherwise step += 1.
- RUN, on each edge with step_en=0:
  - should_spike_out <= 0.
  - All other state holds.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle. should_spike_out = 0.
  - fired_mask, spike_count and inhibited hold their final values for readout.
  - Go to IDLE next edge.
- Results persist through IDLE until the next accepted start.

Timing and boundary rules:
- Latency: input sampled at edge N appears on should_spike_out after edge N (one cycle).
- start during RUN or DONE is ignored. No restart or queueing.
- start in IDLE coincident with step_en: no admission occurs in that first cycle. Admission begins on the first RUN edge.
- Budget 0 (inhibited=1): nothing is admitted; should_spike_out stays 0 for the rest of the cycle.
- All-lines-low with FFI_MAX >= NUM_SPIKES: every line is admitted and spike_count = NUM_SPIKES with no overflow.
- step_en=0 on the final step: the controller stays in RUN; DONE is entered only after a stepped final step.
- Counts saturate by construction: spike_count never exceeds FFI_MAX.
- Input X on should_spike_in_l while not in RUN has no effect.

Test Plan:
- Reset mid-RUN (step=3, spike_count=2), rst_l low -> all outputs 0 immediately. done never pulses. The next start begins a clean cycle.
- Defaults, start, then one step with should_spike_in_l=16'hFFF0 (lines 0-3 low) -> should_spike_out=16'h000F, spike_count=4, inhibited=1. All later steps give should_spike_out=0.
- Defaults, one step with lines 2,5,9,12,14 low -> admitted 16'h1224 (lines 2,5,9,12), line 14 dropped, spike_count=4.
- Line 7 held low for all 8 steps, nothing else -> should_spike_out bit 7 pulses only at step 0. fired_mask=16'h0080, spike_count=1. done pulses once after the 8th stepped edge.
- step_en toggled 1,0,1,0...: the cycle takes 15 stepped/held edges before DONE. Held cycles show should_spike_out=0, and the step value is unchanged across them.
- start asserted during RUN at step 4 -> ignored; step continues 5,6,7 and done pulses once. start in IDLE after done -> fired_mask cleared to 0.

Source files
------------

// File: rtl/ffi_gamma_ctrl_if.sv
// Spike-column bus between the FFI gamma controller and its neighbours.
// master drives requests and cycle control; slave is the controller.
interface ffi_gamma_ctrl_if #(
  parameter int NUM_SPIKES = 16,
  parameter int GAMMA_LEN  = 8,
  parameter int CNT_W      = $clog2(NUM_SPIKES + 1),
  parameter int STEP_W     = $clog2(GAMMA_LEN)
);
  logic                  start;
  logic                  step_en;
  logic [NUM_SPIKES-1:0] should_spike_in_l;
  logic [NUM_SPIKES-1:0] should_spike_out;
  logic [NUM_SPIKES-1:0] fired_mask;
  logic [CNT_W-1:0]      spike_count;
  logic                  inhibited;
  logic                  busy;
  logic                  done;
  logic [STEP_W-1:0]     step;

  modport master (
    output start, step_en, should_spike_in_l,
    input  should_spike_out, fired_mask, spike_count, inhibited, busy, done, step
  );

  modport slave (
    input  start, step_en, should_spike_in_l,
    output should_spike_out, fired_mask, spike_count, inhibited, busy, done, step
  );
endinterface

// File: rtl/ffi_gamma_ctrl.sv
// Feedforward-inhibition sequencer: admits at most FFI_MAX first-time spikes
// per gamma cycle of GAMMA_LEN steps, lowest line index first.
module ffi_gamma_ctrl #(
  parameter int NUM_SPIKES = 16,
  parameter int FFI_MAX    = 4,
  parameter int GAMMA_LEN  = 8,
  parameter int CNT_W      = $clog2(NUM_SPIKES + 1),
  parameter int STEP_W     = $clog2(GAMMA_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_l,
  ffi_gamma_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [NUM_SPIKES-1:0] out_q;
  logic [NUM_SPIKES-1:0] fired_q;
  logic [CNT_W-1:0]      count_q;
  logic                  inhib_q;
  logic                  busy_q;
  logic                  done_q;
  logic [STEP_W-1:0]     step_q;

  logic [NUM_SPIKES-1:0] cand;
  logic [NUM_SPIKES-1:0] admitted;
  logic [CNT_W-1:0]      budget;
  logic [CNT_W-1:0]      admit_cnt;
  logic [CNT_W-1:0]      new_count;

  // Priority admission: walk lines upward, taking candidates until budget is spent.
  always_comb begin
    cand      = ~bus.should_spike_in_l & ~fired_q;
    budget    = CNT_W'(FFI_MAX) - count_q;
    admitted  = '0;
    admit_cnt = '0;
    for (int unsigned i = 0; i < NUM_SPIKES; i++) begin
      if (cand[i] && (admit_cnt < budget)) begin
        admitted[i] = 1'b1;
        admit_cnt   = admit_cnt + CNT_W'(1);
      end
    end
    new_count = count_q + admit_cnt;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state   <= IDLE;
      out_q   <= '0;
      fired_q <= '0;
      count_q <= '0;
      inhib_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_q  <= '0;
          done_q <= 1'b0;
          if (bus.start) begin
            fired_q <= '0;
            count_q <= '0;
            inhib_q <= 1'b0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (bus.step_en) begin
            out_q   <= admitted;
            fired_q <= fired_q | admitted;
            count_q <= new_count;
            inhib_q <= (new_count == CNT_W'(FFI_MAX));
            if (step_q == STEP_W'(GAMMA_LEN - 1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              step_q <= step_q + STEP_W'(1);
            end
          end else begin
            out_q <= '0;
          end
        end
        DONE: begin
          out_q  <= '0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          out_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.should_spike_out = out_q;
  assign bus.fired_mask       = fired_q;
  assign bus.spike_count      = count_q;
  assign bus.inhibited        = inhib_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.step             = step_q;

endmodule

// File: tb/tb_ffi_gamma_ctrl.sv
// Directed bench for ffi_gamma_ctrl: default column (FFI_MAX=4) plus a
// second column with FFI_MAX=NUM_SPIKES for the all-lines-admitted case.
module tb_ffi_gamma_ctrl;

  logic clk;
  logic rst_l;
  int   vectors;
  int   miscompares;

  ffi_gamma_ctrl_if #(.NUM_SPIKES(16), .GAMMA_LEN(8)) bus ();
  ffi_gamma_ctrl_if #(.NUM_SPIKES(16), .GAMMA_LEN(8)) bus2 ();

  ffi_gamma_ctrl #(.NUM_SPIKES(16), .FFI_MAX(4), .GAMMA_LEN(8)) u_dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  ffi_gamma_ctrl #(.NUM_SPIKES(16), .FFI_MAX(16), .GAMMA_LEN(8)) u_full (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cycle();
    bus.step_en = 1'b0;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    bus.start = 1'b0; bus.step_en = 1'b0; bus.should_spike_in_l = 16'hFFFF;
    bus2.start = 1'b0; bus2.step_en = 1'b0; bus2.should_spike_in_l = 16'hFFFF;
    #3;
    vectors++;
    if ({bus.should_spike_out, bus.fired_mask, bus.spike_count, bus.inhibited,
         bus.busy, bus.done, bus.step} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got out=%h mask=%h cnt=%0d inh=%b busy=%b done=%b step=%0d want all 0",
               bus.should_spike_out, bus.fired_mask, bus.spike_count, bus.inhibited,
               bus.busy, bus.done, bus.step);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_l = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    // start coincident with step_en: no admission on the IDLE edge
    bus.should_spike_in_l = 16'hFFF0;
    bus.step_en = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.should_spike_out !== 16'h0 || bus.spike_count !== 5'd0 || bus.step !== 3'd0) begin
      miscompares++;
      $display("FAIL basic_first_edge: got busy=%b out=%h cnt=%0d step=%0d want busy=1 out=0000 cnt=0 step=0",
               bus.busy, bus.should_spike_out, bus.spike_count, bus.step);
    end
    tick();
    vectors++;
    if (bus.should_spike_out !== 16'h000F || bus.spike_count !== 5'd4 || bus.inhibited !== 1'b1 ||
        bus.fired_mask !== 16'h000F || bus.step !== 3'd1) begin
      miscompares++;
      $display("FAIL basic_admit: got out=%h cnt=%0d inh=%b mask=%h step=%0d want out=000f cnt=4 inh=1 mask=000f step=1",
               bus.should_spike_out, bus.spike_count, bus.inhibited, bus.fired_mask, bus.step);
    end
    bus.should_spike_in_l = 16'h0000;
    for (int k = 1; k < 8; k++) begin
      tick();
      vectors++;
      if (bus.should_spike_out !== 16'h0 || bus.spike_count !== 5'd4) begin
        miscompares++;
        $display("FAIL basic_inhibit_k%0d: got out=%h cnt=%0d want out=0000 cnt=4",
                 k, bus.should_spike_out, bus.spike_count);
      end
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
    end
    bus.step_en = 1'b0;
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.fired_mask !== 16'h000F || bus.spike_count !== 5'd4 || bus.inhibited !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_persist: got done=%b mask=%h cnt=%0d inh=%b want done=0 mask=000f cnt=4 inh=1",
               bus.done, bus.fired_mask, bus.spike_count, bus.inhibited);
    end
  endtask

  task automatic test_idle_x();
    bus.should_spike_in_l = 'x;
    bus.step_en = 1'b1;
    repeat (3) tick();
    vectors++;
    if (bus.should_spike_out !== 16'h0 || bus.busy !== 1'b0 || bus.fired_mask !== 16'h000F ||
        bus.spike_count !== 5'd4) begin
      miscompares++;
      $display("FAIL idle_x: got out=%h busy=%b mask=%h cnt=%0d want out=0000 busy=0 mask=000f cnt=4",
               bus.should_spike_out, bus.busy, bus.fired_mask, bus.spike_count);
    end
    bus.step_en = 1'b0;
    bus.should_spike_in_l = 16'hFFFF;
  endtask

  task automatic test_drop();
    start_cycle();
    bus.step_en = 1'b1;
    bus.should_spike_in_l = 16'hADDB;  // lines 2,5,9,12,14 low
    tick();
    vectors++;
    if (bus.should_spike_out !== 16'h1224 || bus.spike_count !== 5'd4 || bus.fired_mask !== 16'h1224) begin
      miscompares++;
      $display("FAIL drop_admit: got out=%h cnt=%0d mask=%h want out=1224 cnt=4 mask=1224",
               bus.should_spike_out, bus.spike_count, bus.fired_mask);
    end
    bus.should_spike_in_l = 16'hFFFF;
    repeat (7) tick();
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_done: got done=%b want 1", bus.done);
    end
    bus.step_en = 1'b0;
    tick();
  endtask

  task automatic test_single_line();
    int dones;
    logic [15:0] exp;
    dones = 0;
    start_cycle();
    bus.step_en = 1'b1;
    bus.should_spike_in_l = 16'hFF7F;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done === 1'b1) dones++;
      exp = (k == 0) ? 16'h0080 : 16'h0000;
      vectors++;
      if (bus.should_spike_out !== exp) begin
        miscompares++;
        $display("FAIL single_out_k%0d: got %h want %h", k, bus.should_spike_out, exp);
      end
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL single_done_edge: got done=%b want 1", bus.done);
    end
    bus.step_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 1 || bus.fired_mask !== 16'h0080 || bus.spike_count !== 5'd1 || bus.inhibited !== 1'b0) begin
      miscompares++;
      $display("FAIL single_final: got dones=%0d mask=%h cnt=%0d inh=%b want dones=1 mask=0080 cnt=1 inh=0",
               dones, bus.fired_mask, bus.spike_count, bus.inhibited);
    end
  endtask

  task automatic test_toggle();
    int nstep;
    logic [2:0]  prev_step;
    logic [15:0] line;
    logic [15:0] exp;
    nstep = 0;
    start_cycle();
    for (int e = 1; e <= 15; e++) begin
      prev_step = bus.step;
      if (e % 2 == 1) begin
        line = 16'h0001 << nstep;
        bus.step_en = 1'b1;
        bus.should_spike_in_l = ~line;
        tick();
        exp = (nstep < 4) ? line : 16'h0000;
        nstep++;
        vectors++;
        if (bus.should_spike_out !== exp) begin
          miscompares++;
          $display("FAIL toggle_step_e%0d: got out=%h want %h", e, bus.should_spike_out, exp);
        end
      end else begin
        bus.step_en = 1'b0;
        bus.should_spike_in_l = 16'h0000;
        tick();
        vectors++;
        if (bus.should_spike_out !== 16'h0 || bus.step !== prev_step || bus.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL toggle_hold_e%0d: got out=%h step=%0d busy=%b want out=0000 step=%0d busy=1",
                   e, bus.should_spike_out, bus.step, bus.busy, prev_step);
        end
      end
      vectors++;
      if (bus.done !== ((e == 15) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL toggle_done_e%0d: got done=%b want %b", e, bus.done, (e == 15));
      end
    end
    bus.step_en = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    int dones;
    dones = 0;
    start_cycle();
    bus.step_en = 1'b1;
    bus.should_spike_in_l = 16'hFFFC;
    tick();
    bus.should_spike_in_l = 16'hFFFF;
    repeat (3) tick();
    vectors++;
    if (bus.step !== 3'd4 || bus.fired_mask !== 16'h0003) begin
      miscompares++;
      $display("FAIL ign_setup: got step=%0d mask=%h want step=4 mask=0003", bus.step, bus.fired_mask);
    end
    bus.start = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      tick();
      bus.start = 1'b0;
      if (bus.done === 1'b1) dones++;
      vectors++;
      if (bus.step !== 3'(k) || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL ign_step_%0d: got step=%0d busy=%b want step=%0d busy=1", k, bus.step, bus.busy, k);
      end
    end
    tick();
    if (bus.done === 1'b1) dones++;
    bus.step_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 1 || bus.fired_mask !== 16'h0003) begin
      miscompares++;
      $display("FAIL ign_done_count: got dones=%0d mask=%h want dones=1 mask=0003", dones, bus.fired_mask);
    end
    start_cycle();
    vectors++;
    if (bus.fired_mask !== 16'h0 || bus.spike_count !== 5'd0 || bus.step !== 3'd0 ||
        bus.inhibited !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear: got mask=%h cnt=%0d step=%0d inh=%b busy=%b want mask=0000 cnt=0 step=0 inh=0 busy=1",
               bus.fired_mask, bus.spike_count, bus.step, bus.inhibited, bus.busy);
    end
    bus.step_en = 1'b1;
    repeat (8) tick();
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_done: got done=%b want 1", bus.done);
    end
    bus.step_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    start_cycle();
    bus.step_en = 1'b1;
    bus.should_spike_in_l = 16'hFFFC;
    tick();
    bus.should_spike_in_l = 16'hFFFF;
    repeat (2) tick();
    bus.step_en = 1'b0;
    vectors++;
    if (bus.step !== 3'd3 || bus.spike_count !== 5'd2) begin
      miscompares++;
      $display("FAIL rmid_setup: got step=%0d cnt=%0d want step=3 cnt=2", bus.step, bus.spike_count);
    end
    #2 rst_l = 1'b0;
    #1;
    vectors++;
    if ({bus.should_spike_out, bus.fired_mask, bus.spike_count, bus.inhibited,
         bus.busy, bus.done, bus.step} !== '0) begin
      miscompares++;
      $display("FAIL rmid_async: got out=%h mask=%h cnt=%0d inh=%b busy=%b done=%b step=%0d want all 0",
               bus.should_spike_out, bus.fired_mask, bus.spike_count, bus.inhibited,
               bus.busy, bus.done, bus.step);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_l = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_no_done: got dones=%0d busy=%b want dones=0 busy=0", dones, bus.busy);
    end
    start_cycle();
    bus.step_en = 1'b1;
    bus.should_spike_in_l = 16'hFFF0;
    tick();
    vectors++;
    if (bus.should_spike_out !== 16'h000F || bus.spike_count !== 5'd4 || bus.step !== 3'd1) begin
      miscompares++;
      $display("FAIL rmid_clean: got out=%h cnt=%0d step=%0d want out=000f cnt=4 step=1",
               bus.should_spike_out, bus.spike_count, bus.step);
    end
    bus.should_spike_in_l = 16'hFFFF;
    repeat (7) tick();
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_done: got done=%b want 1", bus.done);
    end
    bus.step_en = 1'b0;
    tick();
  endtask

  task automatic test_full_column();
    bus2.step_en = 1'b0;
    bus2.start   = 1'b1;
    tick();
    bus2.start   = 1'b0;
    bus2.step_en = 1'b1;
    bus2.should_spike_in_l = 16'h0000;
    tick();
    vectors++;
    if (bus2.should_spike_out !== 16'hFFFF || bus2.spike_count !== 5'd16 || bus2.inhibited !== 1'b1) begin
      miscompares++;
      $display("FAIL full_all_lines: got out=%h cnt=%0d inh=%b want out=ffff cnt=16 inh=1",
               bus2.should_spike_out, bus2.spike_count, bus2.inhibited);
    end
    repeat (7) tick();
    vectors++;
    if (bus2.done !== 1'b1 || bus2.spike_count !== 5'd16 || bus2.fired_mask !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL full_done: got done=%b cnt=%0d mask=%h want done=1 cnt=16 mask=ffff",
               bus2.done, bus2.spike_count, bus2.fired_mask);
    end
    bus2.step_en = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_idle_x();
    test_drop();
    test_single_line();
    test_toggle();
    test_start_ignored();
    test_reset_mid();
    test_full_column();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
